// File: rtl/sched_pkg.sv
// Shared types and sizes for the instruction scheduler.
package sched_pkg;

   localparam int unsigned REG_COUNT  = 16;
   localparam int unsigned REG_ADDR_W = 4;
   localparam int unsigned BLK_W      = 3;

   typedef enum logic [1:0] {IDLE, WAIT, ISSUE} sched_state_t;

   typedef struct packed {
      logic [BLK_W-1:0]      blk;
      logic [REG_ADDR_W-1:0] dest;
      logic [REG_ADDR_W-1:0] src1;
      logic [REG_ADDR_W-1:0] src2;
   } sched_instr_t;

endpackage

// File: rtl/instruction_scheduler_if.sv
// Decoder, result-path and functional-block signals of the scheduler.
interface instruction_scheduler_if
   import sched_pkg::*;
#(
   parameter int unsigned NUM_BLOCKS = 6
) ();

   logic                  instr_valid;
   logic                  instr_ready;
   logic [BLK_W-1:0]      instr_block;
   logic [REG_ADDR_W-1:0] instr_dest;
   logic [REG_ADDR_W-1:0] instr_src1;
   logic [REG_ADDR_W-1:0] instr_src2;
   logic [REG_COUNT-1:0]  dependency_remove;
   logic [NUM_BLOCKS-1:0] block_ready;
   logic [NUM_BLOCKS-1:0] issue_enable;
   logic [REG_ADDR_W-1:0] issue_dest;
   logic [REG_ADDR_W-1:0] issue_src1;
   logic [REG_ADDR_W-1:0] issue_src2;
   logic [REG_COUNT-1:0]  busy_regs;
   logic                  illegal_instr;

   // Environment side: decoder, result path and functional blocks.
   modport master (
      output instr_valid, instr_block, instr_dest, instr_src1, instr_src2,
      output dependency_remove, block_ready,
      input  instr_ready, issue_enable, issue_dest, issue_src1, issue_src2,
      input  busy_regs, illegal_instr
   );

   // Scheduler side.
   modport slave (
      input  instr_valid, instr_block, instr_dest, instr_src1, instr_src2,
      input  dependency_remove, block_ready,
      output instr_ready, issue_enable, issue_dest, issue_src1, issue_src2,
      output busy_regs, illegal_instr
   );

endinterface

// File: rtl/reg_scoreboard.sv
// 16-entry busy-register scoreboard; a set wins over a same-cycle clear.
module reg_scoreboard
   import sched_pkg::*;
(
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  set_en,
   input  logic [REG_ADDR_W-1:0] set_addr,
   input  logic [REG_COUNT-1:0]  clear,
   output logic [REG_COUNT-1:0]  busy
);

   logic [REG_COUNT-1:0] set_mask;
   logic [REG_COUNT-1:0] busy_d;

   // Next scoreboard: apply clears first, then the issue's set.
   always_comb begin
      set_mask = '0;
      if (set_en) begin
         set_mask[set_addr] = 1'b1;
      end
      busy_d = (busy & ~clear) | set_mask;
   end

   // Scoreboard register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         busy <= '0;
      end else begin
         busy <= busy_d;
      end
   end

endmodule

// File: rtl/instruction_scheduler.sv
// Single-instruction scheduler: holds one decoded instruction, waits for
// RAW/WAW hazards and the target block, then issues a one-cycle strobe.
module instruction_scheduler
   import sched_pkg::*;
#(
   parameter int unsigned NUM_BLOCKS = 6
) (
   input  logic                     clk,
   input  logic                     n_rst,
   instruction_scheduler_if.slave   bus
);

   sched_state_t          state_q, state_d;
   sched_instr_t          instr_q, instr_d;
   logic [NUM_BLOCKS-1:0] issue_enable_q, issue_enable_d;
   logic [REG_ADDR_W-1:0] issue_dest_q, issue_dest_d;
   logic [REG_ADDR_W-1:0] issue_src1_q, issue_src1_d;
   logic [REG_ADDR_W-1:0] issue_src2_q, issue_src2_d;
   logic                  illegal_q, illegal_d;
   logic                  set_en;
   logic [REG_COUNT-1:0]  busy;
   logic [REG_COUNT-1:0]  eff_busy;
   logic [7:0]            ready_ext;
   logic [7:0]            blk_onehot;
   logic                  blk_legal;
   logic                  can_issue;

   reg_scoreboard u_scoreboard (
      .clk      (clk),
      .n_rst    (n_rst),
      .set_en   (set_en),
      .set_addr (instr_q.dest),
      .clear    (bus.dependency_remove),
      .busy     (busy)
   );

   // Hazard check; same-cycle clears bypass the scoreboard register.
   always_comb begin
      eff_busy   = busy & ~bus.dependency_remove;
      ready_ext  = 8'(bus.block_ready);
      blk_onehot = 8'(1) << instr_q.blk;
      blk_legal  = 32'(bus.instr_block) < NUM_BLOCKS;
      can_issue  = !eff_busy[instr_q.src1] && !eff_busy[instr_q.src2] &&
                   !eff_busy[instr_q.dest] && ready_ext[instr_q.blk];
   end

   // FSM state register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.instr_valid && blk_legal) state_d = WAIT;
         WAIT:    if (can_issue) state_d = ISSUE;
         ISSUE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: capture, illegal flag, issue strobe and scoreboard set.
   always_comb begin
      instr_d        = instr_q;
      illegal_d      = 1'b0;
      issue_enable_d = '0;
      issue_dest_d   = issue_dest_q;
      issue_src1_d   = issue_src1_q;
      issue_src2_d   = issue_src2_q;
      set_en         = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.instr_valid) begin
               instr_d   = '{blk: bus.instr_block, dest: bus.instr_dest,
                             src1: bus.instr_src1, src2: bus.instr_src2};
               illegal_d = !blk_legal;
            end
         end
         WAIT: begin
            if (can_issue) begin
               set_en         = 1'b1;
               issue_enable_d = blk_onehot[NUM_BLOCKS-1:0];
               issue_dest_d   = instr_q.dest;
               issue_src1_d   = instr_q.src1;
               issue_src2_d   = instr_q.src2;
            end
         end
         default: ;
      endcase
   end

   // Held instruction and registered issue outputs.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         instr_q        <= '0;
         illegal_q      <= 1'b0;
         issue_enable_q <= '0;
         issue_dest_q   <= '0;
         issue_src1_q   <= '0;
         issue_src2_q   <= '0;
      end else begin
         instr_q        <= instr_d;
         illegal_q      <= illegal_d;
         issue_enable_q <= issue_enable_d;
         issue_dest_q   <= issue_dest_d;
         issue_src1_q   <= issue_src1_d;
         issue_src2_q   <= issue_src2_d;
      end
   end

   assign bus.instr_ready   = (state_q == IDLE);
   assign bus.issue_enable  = issue_enable_q;
   assign bus.issue_dest    = issue_dest_q;
   assign bus.issue_src1    = issue_src1_q;
   assign bus.issue_src2    = issue_src2_q;
   assign bus.busy_regs     = busy;
   assign bus.illegal_instr = illegal_q;

endmodule

// File: tb/tb_instruction_scheduler.sv
// Self-checking bench for instruction_scheduler: vector table, corner-case
// sequences and a randomized run against a transaction-level model.
module tb_instruction_scheduler;

   localparam int NB = 6;

   logic clk = 1'b0;
   logic n_rst;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   instruction_scheduler_if #(.NUM_BLOCKS(NB)) bus ();

   instruction_scheduler #(.NUM_BLOCKS(NB)) dut (
      .clk   (clk),
      .n_rst (n_rst),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [2:0]  blk;
      logic [3:0]  dest;
      logic [3:0]  s1;
      logic [3:0]  s2;
      logic [5:0]  en;
      logic [15:0] busy;
      logic        ill;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Present one instruction for a single edge; returns at the next negedge.
   task automatic send(input logic [2:0] b, input logic [3:0] d, input logic [3:0] s1,
                       input logic [3:0] s2);
      bus.instr_valid = 1'b1;
      bus.instr_block = b;
      bus.instr_dest  = d;
      bus.instr_src1  = s1;
      bus.instr_src2  = s2;
      tick();
      bus.instr_valid = 1'b0;
   endtask

   task automatic clear_all();
      bus.dependency_remove = 16'hffff;
      tick();
      bus.dependency_remove = 16'h0000;
   endtask

   task automatic do_reset();
      n_rst = 1'b0;
      tick();
      tick();
      n_rst = 1'b1;
      tick();
   endtask

   // Model state for the random run.
   bit         mb[16];
   int         ph;          // 0: free, 1: holding, 2: strobe cycle
   logic [2:0] mblk;
   logic [3:0] md, m1, m2;
   bit         mill;

   initial begin
      logic [5:0]  e;
      logic [15:0] bb;
      logic [15:0] dep;
      logic [5:0]  rdy;
      bit          nb[16];
      bit          go;

      vecs[0] = '{blk: 3'd2, dest: 4'd5,  s1: 4'd1,  s2: 4'd3,  en: 6'b000100, busy: 16'h0020, ill: 1'b0};
      vecs[1] = '{blk: 3'd0, dest: 4'd0,  s1: 4'd0,  s2: 4'd0,  en: 6'b000001, busy: 16'h0001, ill: 1'b0};
      vecs[2] = '{blk: 3'd5, dest: 4'd15, s1: 4'd14, s2: 4'd13, en: 6'b100000, busy: 16'h8000, ill: 1'b0};
      vecs[3] = '{blk: 3'd3, dest: 4'd9,  s1: 4'd9,  s2: 4'd2,  en: 6'b001000, busy: 16'h0200, ill: 1'b0};
      vecs[4] = '{blk: 3'd6, dest: 4'd4,  s1: 4'd1,  s2: 4'd2,  en: 6'b000000, busy: 16'h0000, ill: 1'b1};
      vecs[5] = '{blk: 3'd7, dest: 4'd1,  s1: 4'd1,  s2: 4'd1,  en: 6'b000000, busy: 16'h0000, ill: 1'b1};

      bus.instr_valid       = 1'b0;
      bus.instr_block       = '0;
      bus.instr_dest        = '0;
      bus.instr_src1        = '0;
      bus.instr_src2        = '0;
      bus.dependency_remove = '0;
      bus.block_ready       = '1;
      n_rst                 = 1'b0;
      tick();
      do_reset();

      // Reset state.
      chk("rst_ready", 32'(bus.instr_ready), 32'h1);
      chk("rst_en", 32'(bus.issue_enable), 32'h0);
      chk("rst_busy", 32'(bus.busy_regs), 32'h0);
      chk("rst_illegal", 32'(bus.illegal_instr), 32'h0);
      chk("rst_dest", 32'(bus.issue_dest), 32'h0);

      // Vector table: single instructions against a cleared scoreboard.
      for (int i = 0; i < 6; i++) begin
         clear_all();
         send(vecs[i].blk, vecs[i].dest, vecs[i].s1, vecs[i].s2);
         chk("vec_illegal", 32'(bus.illegal_instr), 32'(vecs[i].ill));
         chk("vec_ready", 32'(bus.instr_ready), 32'(vecs[i].ill));
         chk("vec_wait_en", 32'(bus.issue_enable), 32'h0);
         tick();
         chk("vec_en", 32'(bus.issue_enable), 32'(vecs[i].en));
         chk("vec_busy", 32'(bus.busy_regs), 32'(vecs[i].busy));
         chk("vec_ill_clr", 32'(bus.illegal_instr), 32'h0);
         if (!vecs[i].ill) begin
            chk("vec_dest", 32'(bus.issue_dest), 32'(vecs[i].dest));
            chk("vec_src1", 32'(bus.issue_src1), 32'(vecs[i].s1));
            chk("vec_src2", 32'(bus.issue_src2), 32'(vecs[i].s2));
         end
         tick();
      end

      // Reset mid-WAIT with register 4 pending.
      clear_all();
      send(3'd1, 4'd4, 4'd0, 4'd0);
      tick();
      tick();
      send(3'd2, 4'd6, 4'd4, 4'd0);
      tick();
      chk("t1_stall_ready", 32'(bus.instr_ready), 32'h0);
      chk("t1_busy", 32'(bus.busy_regs), 32'h0010);
      #2 n_rst = 1'b0;
      #1;
      chk("t1_async_busy", 32'(bus.busy_regs), 32'h0);
      chk("t1_async_en", 32'(bus.issue_enable), 32'h0);
      chk("t1_async_ready", 32'(bus.instr_ready), 32'h1);
      chk("t1_async_dest", 32'(bus.issue_dest), 32'h0);
      tick();
      n_rst = 1'b1;
      tick();
      chk("t1_ready", 32'(bus.instr_ready), 32'h1);
      chk("t1_en", 32'(bus.issue_enable), 32'h0);
      tick();
      chk("t1_en2", 32'(bus.issue_enable), 32'h0);
      chk("t1_busy2", 32'(bus.busy_regs), 32'h0);

      // RAW stall released by a same-cycle clear; dest re-set wins.
      send(3'd0, 4'd5, 4'd1, 4'd2);
      tick();
      chk("t3_first_en", 32'(bus.issue_enable), 32'h01);
      tick();
      send(3'd1, 4'd5, 4'd5, 4'd0);
      for (int i = 0; i < 3; i++) begin
         chk("t3_stall_en", 32'(bus.issue_enable), 32'h0);
         chk("t3_stall_ready", 32'(bus.instr_ready), 32'h0);
         tick();
      end
      bus.dependency_remove = 16'h0020;
      tick();
      bus.dependency_remove = 16'h0000;
      chk("t3_en", 32'(bus.issue_enable), 32'h02);
      chk("t3_busy", 32'(bus.busy_regs), 32'h0020);
      tick();
      chk("t3_idle_ready", 32'(bus.instr_ready), 32'h1);
      chk("t3_idle_busy", 32'(bus.busy_regs), 32'h0020);

      // Set/clear collision on register 7.
      clear_all();
      send(3'd3, 4'd7, 4'd1, 4'd2);
      bus.dependency_remove = 16'h0080;
      tick();
      bus.dependency_remove = 16'h0000;
      chk("t4_en", 32'(bus.issue_enable), 32'h08);
      chk("t4_busy", 32'(bus.busy_regs), 32'h0080);
      tick();

      // Target block not ready: unbounded stall, then issue.
      clear_all();
      bus.block_ready = 6'b101111;
      send(3'd4, 4'd8, 4'd9, 4'd10);
      for (int i = 0; i < 10; i++) begin
         chk("t5_stall_en", 32'(bus.issue_enable), 32'h0);
         tick();
      end
      bus.block_ready = '1;
      tick();
      bus.block_ready = 6'b000000;
      chk("t5_en", 32'(bus.issue_enable), 32'h10);
      chk("t5_dest", 32'(bus.issue_dest), 32'h8);
      chk("t5_src1", 32'(bus.issue_src1), 32'h9);
      chk("t5_src2", 32'(bus.issue_src2), 32'hA);
      tick();
      bus.block_ready = '1;

      // Illegal block with a non-empty scoreboard.
      send(3'd6, 4'd3, 4'd3, 4'd3);
      chk("t6_illegal", 32'(bus.illegal_instr), 32'h1);
      chk("t6_busy", 32'(bus.busy_regs), 32'h0100);
      chk("t6_ready", 32'(bus.instr_ready), 32'h1);
      tick();
      chk("t6_pulse_end", 32'(bus.illegal_instr), 32'h0);
      chk("t6_no_issue", 32'(bus.issue_enable), 32'h0);

      // Randomized run against the model.
      do_reset();
      for (int r = 0; r < 16; r++) mb[r] = 1'b0;
      ph   = 0;
      mill = 1'b0;
      mblk = '0;
      md   = '0;
      m1   = '0;
      m2   = '0;
      for (int c = 0; c < 800; c++) begin
         e = '0;
         if (ph == 2) e[mblk] = 1'b1;
         for (int r = 0; r < 16; r++) bb[r] = mb[r];
         chk("rnd_ready", 32'(bus.instr_ready), 32'(ph == 0));
         chk("rnd_en", 32'(bus.issue_enable), 32'(e));
         chk("rnd_busy", 32'(bus.busy_regs), 32'(bb));
         chk("rnd_illegal", 32'(bus.illegal_instr), 32'(mill));
         if (ph == 2) begin
            chk("rnd_dest", 32'(bus.issue_dest), 32'(md));
            chk("rnd_src1", 32'(bus.issue_src1), 32'(m1));
            chk("rnd_src2", 32'(bus.issue_src2), 32'(m2));
         end

         dep = '0;
         for (int r = 0; r < 16; r++) dep[r] = ($urandom_range(0, 5) == 0);
         for (int b = 0; b < NB; b++) rdy[b] = ($urandom_range(0, 3) != 0);
         bus.instr_valid       = 1'($urandom_range(0, 1));
         bus.instr_block       = 3'($urandom_range(0, 7));
         bus.instr_dest        = 4'($urandom_range(0, 3));
         bus.instr_src1        = 4'($urandom_range(0, 3));
         bus.instr_src2        = 4'($urandom_range(0, 3));
         bus.dependency_remove = dep;
         bus.block_ready       = rdy;

         // A register is free if not pending or its result arrives now.
         for (int r = 0; r < 16; r++) nb[r] = mb[r] && !dep[r];
         mill = 1'b0;
         if (ph == 0) begin
            if (bus.instr_valid) begin
               mblk = bus.instr_block;
               md   = bus.instr_dest;
               m1   = bus.instr_src1;
               m2   = bus.instr_src2;
               if (int'(bus.instr_block) >= NB) mill = 1'b1;
               else ph = 1;
            end
         end else if (ph == 1) begin
            go = !nb[m1] && !nb[m2] && !nb[md] && rdy[mblk];
            if (go) begin
               nb[md] = 1'b1;
               ph     = 2;
            end
         end else begin
            ph = 0;
         end
         for (int r = 0; r < 16; r++) mb[r] = nb[r];
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
